// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//
// Burst read initiator for the data_ram read port. A start pulse latches a
// base address and a word count; the block then issues sequential reads,
// tags the returning words with a RD_LATENCY-deep valid pipeline, and buffers
// them in a small FIFO. The FIFO is presented downstream as a valid/ready
// stream.
//
// Reads are only issued while reads in flight plus buffered words are below
// FIFO_DEPTH. Because of this, every returning word has a reserved slot, and
// backpressure can never overflow the buffer.
//
// Ports
//   clk          single clock, also the RAM port clock
//   rst          asynchronous active-high reset
//   start        begin a burst (only looked at in IDLE)
//   base_addr    first word address, latched on start
//   length       number of words (0 .. 2^ADDR_W), latched on start
//   busy         burst in progress (RUN or DRAIN)
//   done         one-cycle completion pulse
//   ram_address  RAM read address
//   ram_rden     RAM read enable
//   ram_q        RAM read data, valid RD_LATENCY edges after ram_rden is sampled
//   out_data     stream data (FIFO head, zero when empty)
//   out_valid    stream valid
//   out_ready    stream ready; a word moves when out_valid && out_ready

module ram_stream_reader #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 24,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_rden,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int LAT_W = $clog2(RD_LATENCY + 1);
  localparam int OCC_W = CNT_W + LAT_W;

  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]  ONE       = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Burst control state.
  state_t            state_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W:0]   length_reg;
  logic [ADDR_W:0]   issued_reg;

  // Return path and buffer state.
  logic [RD_LATENCY-1:0] tag_reg;
  logic [LAT_W-1:0]      inflight_reg;
  logic [LAT_W-1:0]      inflight_next;
  logic [CNT_W-1:0]      count_reg;
  logic [CNT_W-1:0]      count_next;
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [DATA_W-1:0]     fifo_mem [FIFO_DEPTH];

  logic [OCC_W-1:0] occupancy;
  logic             issue;
  logic             last_issue;
  logic             wr_en;
  logic             pop;
  logic             head_valid;

  always_comb begin
    // Occupancy comes from registered counters only. A pop in this cycle
    // therefore frees its slot one cycle later, and that keeps the credit
    // check conservative.
    occupancy     = OCC_W'(inflight_reg) + OCC_W'(count_reg);
    issue         = (state_reg == RUN) && (issued_reg < length_reg) &&
                    (occupancy < DEPTH_OCC);
    last_issue    = issue && ((issued_reg + ONE) == length_reg);
    wr_en         = tag_reg[RD_LATENCY-1];
    head_valid    = (count_reg != '0);
    pop           = head_valid && out_ready;
    inflight_next = inflight_reg + LAT_W'(issue) - LAT_W'(wr_en);
    count_next    = count_reg + CNT_W'(wr_en) - CNT_W'(pop);
  end

  // The address counter is ADDR_W+1 bits, but only the low bits reach the
  // RAM. Because of this, a burst wraps from the top of the address space to 0.
  assign ram_rden    = issue;
  assign ram_address = base_reg + issued_reg[ADDR_W-1:0];

  // The head is shown directly from the register array. It cannot change
  // while it is valid and not popped, because writes only go to the tail.
  assign out_valid = head_valid;
  assign out_data  = head_valid ? fifo_mem[rd_ptr_reg] : '0;

  assign busy = (state_reg == RUN) || (state_reg == DRAIN);
  assign done = (state_reg == DONE);

  // Control FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      base_reg   <= '0;
      length_reg <= '0;
      issued_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            base_reg   <= base_addr;
            length_reg <= length;
            issued_reg <= '0;
            state_reg  <= (length == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (issue) begin
            issued_reg <= issued_reg + ONE;
            if (last_issue) begin
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Leave on the edge that moves the final word downstream. The done
          // pulse then appears in the very next cycle.
          if ((inflight_next == '0) && (count_next == '0)) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Tag pipeline: bit k is high when the read issued k+1 cycles ago is on its
  // way. The last stage lines up with valid ram_q. Clearing it on reset
  // drops any data still coming back from reads issued before the reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_reg <= '0;
    end else begin
      tag_reg[0] <= issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_reg[i] <= tag_reg[i-1];
      end
    end
  end

  // FIFO bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_reg <= '0;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      inflight_reg <= inflight_next;
      count_reg    <= count_next;
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
    end
  end

  // FIFO storage has no reset. Contents are only visible through out_data
  // while count is non-zero.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_mem[wr_ptr_reg] <= ram_q;
    end
  end

endmodule
